// File: rtl/light_control_multi.sv
// Multi-room lighting controller: a shared debounced night flag gates per-room
// occupancy FSMs with a hold timer and per-room manual override.
module light_control_multi #(
    parameter int N_ROOMS     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int DEB_CYCLES  = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           light_in,
    input  logic [N_ROOMS-1:0]             occ_in,
    input  logic [N_ROOMS-1:0]             manual_en,
    input  logic [N_ROOMS-1:0]             manual_on,
    output logic [N_ROOMS-1:0]             light_out,
    output logic [$clog2(N_ROOMS+1)-1:0]   active_cnt,
    output logic                           night
);

    localparam int CW = $clog2(N_ROOMS + 1);
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } room_state_t;

    room_state_t       state_r      [N_ROOMS];
    logic [TW-1:0]     timer_r      [N_ROOMS];
    room_state_t       state_nxt_s  [N_ROOMS];
    logic [TW-1:0]     timer_nxt_s  [N_ROOMS];
    logic [N_ROOMS-1:0] light_nxt_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic [DW-1:0]     deb_cnt_r;
    logic              mismatch_s;

    function automatic logic [CW-1:0] popcount(input logic [N_ROOMS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N_ROOMS; k++) begin
            c = c + CW'(v[k]);
        end
        return c;
    endfunction

    // Sensor reads 1 for daylight, so darkness disagrees with night when ~light_in != night.
    always_comb begin
        mismatch_s = (~light_in) != night;
    end

    // Debounce counter and night flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            night     <= 1'b0;
            deb_cnt_r <= '0;
        end else if (mismatch_s) begin
            if (deb_cnt_r == DEB_LAST) begin
                night     <= ~night;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end else begin
            deb_cnt_r <= '0;
        end
    end

    // Per-room next-state, timer and lamp value; rooms read the registered night flag.
    always_comb begin
        light_nxt_s = '0;
        for (int i = 0; i < N_ROOMS; i++) begin
            state_nxt_s[i] = state_r[i];
            timer_nxt_s[i] = timer_r[i];
            if (manual_en[i]) begin
                state_nxt_s[i] = ST_OFF;
                timer_nxt_s[i] = '0;
            end else begin
                case (state_r[i])
                    ST_OFF: begin
                        if (night && occ_in[i]) begin
                            state_nxt_s[i] = ST_ON;
                        end else begin
                            state_nxt_s[i] = ST_OFF;
                        end
                    end
                    ST_ON: begin
                        if (!night) begin
                            state_nxt_s[i] = ST_OFF;
                        end else if (!occ_in[i]) begin
                            state_nxt_s[i] = ST_HOLD;
                            timer_nxt_s[i] = HOLD_LOAD;
                        end else begin
                            state_nxt_s[i] = ST_ON;
                        end
                    end
                    ST_HOLD: begin
                        if (!night) begin
                            state_nxt_s[i] = ST_OFF;
                        end else if (occ_in[i]) begin
                            state_nxt_s[i] = ST_ON;
                        end else if (timer_r[i] == '0) begin
                            state_nxt_s[i] = ST_OFF;
                        end else begin
                            timer_nxt_s[i] = timer_r[i] - TW'(1);
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_OFF;
                        timer_nxt_s[i] = '0;
                    end
                endcase
            end
            if (manual_en[i]) begin
                light_nxt_s[i] = manual_on[i];
            end else begin
                light_nxt_s[i] = (state_nxt_s[i] != ST_OFF);
            end
        end
        cnt_nxt_s = popcount(light_nxt_s);
    end

    // Room state registers and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ROOMS; i++) begin
                state_r[i] <= ST_OFF;
                timer_r[i] <= '0;
            end
            light_out  <= '0;
            active_cnt <= '0;
        end else begin
            for (int i = 0; i < N_ROOMS; i++) begin
                state_r[i] <= state_nxt_s[i];
                timer_r[i] <= timer_nxt_s[i];
            end
            light_out  <= light_nxt_s;
            active_cnt <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_light_control_multi.sv
// Scoreboard bench for light_control_multi: each driven cycle queues its expected
// outputs, and a monitor compares them one edge later.
module tb_light_control_multi;

    logic       clk;
    logic       rst_n;
    logic       light_in;
    logic [3:0] occ_in;
    logic [3:0] manual_en;
    logic [3:0] manual_on;
    logic [3:0] light_out;
    logic [2:0] active_cnt;
    logic       night;

    typedef struct {
        logic [3:0] l;
        logic [2:0] c;
        logic       n;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    light_control_multi #(
        .N_ROOMS(4),
        .HOLD_CYCLES(16),
        .DEB_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .light_in(light_in),
        .occ_in(occ_in),
        .manual_en(manual_en),
        .manual_on(manual_on),
        .light_out(light_out),
        .active_cnt(active_cnt),
        .night(night)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the next edge must produce.
    task automatic step(input logic li, input logic [3:0] occ, input logic [3:0] men,
                        input logic [3:0] mon, input logic rn, input logic [3:0] el,
                        input logic [2:0] ec, input logic en, input int tag);
        exp_t x;
        @(negedge clk);
        light_in  = li;
        occ_in    = occ;
        manual_en = men;
        manual_on = mon;
        rst_n     = rn;
        x.l = el; x.c = ec; x.n = en; x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: compare registered outputs just after each edge that has an expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (light_out !== e.l) begin
                errors++;
                $display("FAIL light_out phase %0d t=%0t: got %b expected %b", e.tag, $time, light_out, e.l);
            end
            checks++;
            if (active_cnt !== e.c) begin
                errors++;
                $display("FAIL active_cnt phase %0d t=%0t: got %0d expected %0d", e.tag, $time, active_cnt, e.c);
            end
            checks++;
            if (night !== e.n) begin
                errors++;
                $display("FAIL night phase %0d t=%0t: got %b expected %b", e.tag, $time, night, e.n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; light_in = 1'b1; occ_in = 4'b0000;
        manual_en = 4'b0000; manual_on = 4'b0000;

        // 1: reset wins over manual override
        repeat (2) step(1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 3'd0, 1'b0, 1);
        // 2: idle daylight
        repeat (2) step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 2);
        // 3: two-cycle dark glitch, occupancy ignored in daylight
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3);
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3);
        step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3);
        // 4: darkness accepted after the third edge
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 4);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 4);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b1, 4);
        // 5: basic hold of 16 edges
        repeat (5) step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b1, 5);
        for (int k = 0; k < 17; k++)
            step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 (k < 16) ? 4'b0001 : 4'b0000, (k < 16) ? 3'd1 : 3'd0, 1'b1, 5);
        // 6: re-occupancy during hold restarts the full hold
        repeat (2) step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b1, 6);
        repeat (10) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b1, 6);
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b1, 6);
        for (int k = 0; k < 17; k++)
            step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 (k < 16) ? 4'b0001 : 4'b0000, (k < 16) ? 3'd1 : 3'd0, 1'b1, 6);
        // 7: all rooms on, then daylight cut-off
        repeat (2) step(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1111, 3'd4, 1'b1, 7);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1111, 3'd4, 1'b1, 7);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1111, 3'd4, 1'b1, 7);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b1111, 3'd4, 1'b0, 7);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 7);
        // 8: manual override in daylight, then release
        repeat (2) step(1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b1, 4'b0100, 3'd1, 1'b0, 8);
        step(1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 4'b0000, 3'd0, 1'b0, 8);
        step(1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000, 3'd0, 1'b0, 8);
        // 9: reset during hold, night must be re-debounced
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 9);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 9);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b1, 9);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b1, 9);
        repeat (2) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b1, 9);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 9);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 9);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 9);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b1, 9);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b1, 9);
        // 10: manual off at night, release resumes with occupancy, rooms independent
        step(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b1, 10);
        step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b1, 10);
        step(1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b1, 4'b1010, 3'd2, 1'b1, 10);
        step(1'b0, 4'b1000, 4'b0001, 4'b0001, 1'b1, 4'b1011, 3'd3, 1'b1, 10);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
